// File: rtl/lcd_rd_feeder.sv
// rtl/lcd_rd_feeder.sv - LCD pixel-word feeder: prefetches SDRAM read bursts into a FIFO and serves lcd_rden.
// Optional: LCD_FEED_HOLD_LAST_EN makes an empty pop hold the previous lcd_data instead of driving 0.
module lcd_rd_feeder #(
    parameter int DATA_W      = 96,
    parameter int FIFO_DEPTH  = 16,
    parameter int BURST_LEN   = 4,
    parameter int ADDR_W      = 24,
    parameter int FRAME_WORDS = 96000
) (
    input  logic                            clk_lcd,
    input  logic                            lcd_rst,
    input  logic                            lcd_rden,
    input  logic                            lcd_framesync,
    input  logic                            sdr_addr_set,
    output logic [DATA_W-1:0]               lcd_data,
    output logic                            rd_req,
    output logic [ADDR_W-1:0]               rd_addr,
    input  logic                            rd_ack,
    input  logic                            rd_valid,
    input  logic [DATA_W-1:0]               rd_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underflow,
    output logic                            frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int CW = $clog2(FRAME_WORDS) + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr, r_rptr;
    logic [BW-1:0]       r_beat;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_flush_pend;
    logic [DATA_W-1:0]   r_data;
    logic                r_underflow, r_frame_err;
    logic                r_fs_d, r_exempt;
    logic [CW-1:0]       r_pop_cnt;

    logic [PW-1:0]       w_level;
    logic                w_empty, w_flush_req, w_flush, w_pop, w_push, w_room, w_last_beat, w_fs_rise;
    logic [ADDR_W-1:0]   w_addr_inc, w_addr_nxt;

    assign w_level     = r_wptr - r_rptr;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_flush_req = sdr_addr_set | r_flush_pend;
    // A pending flush is only carried out once no burst is in flight.
    assign w_flush     = (r_state == ST_IDLE) & w_flush_req;
    assign w_pop       = lcd_rden & ~w_empty & ~sdr_addr_set;
    assign w_push      = (r_state == ST_DATA) & rd_valid & ~w_flush_req;
    assign w_room      = ({{(32-PW){1'b0}}, w_level} + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
    assign w_last_beat = rd_valid & (r_beat == BW'(BURST_LEN - 1));
    assign w_fs_rise   = lcd_framesync & ~r_fs_d;
    assign w_addr_inc  = r_addr + ADDR_W'(BURST_LEN);
    assign w_addr_nxt  = (w_addr_inc == ADDR_W'(FRAME_WORDS)) ? '0 : w_addr_inc;

    always_comb begin
        w_state_nxt = r_state;
        rd_req      = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_flush && w_room) w_state_nxt = ST_REQ;
            ST_REQ: begin
                rd_req = 1'b1;
                if (rd_ack) w_state_nxt = ST_DATA;
            end
            ST_DATA: if (w_last_beat) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_lcd) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= rd_data;
    end

    always_ff @(posedge clk_lcd or posedge lcd_rst) begin
        if (lcd_rst) begin
            r_state      <= ST_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_beat       <= '0;
            r_addr       <= '0;
            r_flush_pend <= 1'b0;
            r_data       <= '0;
            r_underflow  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_fs_d       <= 1'b0;
            r_exempt     <= 1'b1;
            r_pop_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fs_d  <= lcd_framesync;

            if (r_state == ST_DATA && rd_valid)
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;

            if (w_flush)
                r_addr <= '0;
            else if (r_state == ST_REQ && rd_ack)
                r_addr <= w_addr_nxt;

            if (w_flush)
                r_flush_pend <= 1'b0;
            else if (sdr_addr_set)
                r_flush_pend <= 1'b1;

            if (w_push) r_wptr <= r_wptr + 1'b1;

            // Discarding stored words is immediate; address/counter restart waits for w_flush.
            if (sdr_addr_set || w_flush)
                r_rptr <= r_wptr;
            else if (w_pop)
                r_rptr <= r_rptr + 1'b1;

            if (lcd_rden) begin
                if (sdr_addr_set)
                    r_data <= '0;
                else if (!w_empty)
                    r_data <= r_mem[r_rptr[AW-1:0]];
                else begin
`ifdef LCD_FEED_HOLD_LAST_EN
                    r_data <= r_data;
`else
                    r_data <= '0;
`endif
                    r_underflow <= 1'b1;
                end
            end

            if (w_flush) begin
                r_pop_cnt <= '0;
                r_exempt  <= 1'b1;
            end else if (w_fs_rise) begin
                if (!r_exempt && r_pop_cnt != CW'(FRAME_WORDS))
                    r_frame_err <= 1'b1;
                r_exempt  <= 1'b0;
                r_pop_cnt <= w_pop ? CW'(1) : '0;
            end else if (w_pop && r_pop_cnt != '1) begin
                r_pop_cnt <= r_pop_cnt + 1'b1;
            end
        end
    end

    assign lcd_data   = r_data;
    assign rd_addr    = r_addr;
    assign fifo_level = w_level;
    assign underflow  = r_underflow;
    assign frame_err  = r_frame_err;
endmodule
